// File: rtl/x_mem_rsp_pkg.sv
// Shared types and constants for the x_mem_rsp memory responder.
package x_mem_rsp_pkg;

  // Request-handling FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } rsp_sm_t;

  // Address decode result for a request.
  typedef enum logic [1:0] {
    RAM,
    GPIO,
    NONE
  } rsp_sel_t;

  // Default byte address of the GPIO register.
  localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'h8000_0000;

  // Width of the wait-state counter (WAIT_CYCLES is 0..15).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/x_mem_rsp_ram.sv
// Single-port word RAM: one write port (caller resolves priority) and one
// registered read port. The array itself carries no reset.
module x_mem_rsp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  // NOTE: sequential state is updated with <= so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/x_mem_rsp.sv
// Memory-side responder: word RAM plus one memory-mapped GPIO register on a
// valid/accept request bus, with optional wait states and a side-band loader.
// Optional feature: define X_MEM_RSP_ERR_EN for the sticky o_err access-error flag.
module x_mem_rsp
  import x_mem_rsp_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] GPIO_ADDR   = GPIO_ADDR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  input  logic        i_ld_en,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_gpio,
  output logic        o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  rsp_sm_t           state, state_next;
  logic [WAIT_W-1:0] cnt, cnt_next;
  rsp_sel_t          sel, sel_q;
  logic [31:0]       rsp_q, gpio_q, ram_rdata, ram_wdata;
  logic [AW-1:0]     ram_waddr;
  logic              ack, rd_en, req_we, gpio_we, ram_we;

  // Address decode of the current request; GPIO takes precedence over RAM.
  always_comb begin
    if (i_addr[31:2] == GPIO_ADDR[31:2]) sel = GPIO;
    else if ({1'b0, i_addr} < RAM_BYTES) sel = RAM;
    else                                 sel = NONE;
  end

  // FSM state and wait counter registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: new requests start only while the loader is idle;
  // a request that drops valid before its accept is abandoned.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (i_valid && !i_ld_en) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ACK;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!i_valid)        state_next = IDLE;
        else if (cnt == '0)  state_next = ACK;
        else                 cnt_next   = cnt - 1'b1;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and derived strobes.
  always_comb begin
    ack      = (state == ACK);
    o_accept = ack;
    rd_en    = (state_next == ACK) && i_rnw;
    req_we   = ack && i_valid && !i_rnw && (sel == RAM);
    gpio_we  = ack && i_valid && !i_rnw && (sel == GPIO);
    ram_we   = i_ld_en || req_we;
    if (i_ld_en) begin
      ram_waddr = i_ld_addr[AW+1:2];
      ram_wdata = i_ld_data;
    end else begin
      ram_waddr = i_addr[AW+1:2];
      ram_wdata = i_data;
    end
  end

  // Read response capture on the edge entering ACK; non-RAM reads are
  // resolved here, RAM reads come from the RAM's own read register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sel_q <= NONE;
      rsp_q <= '0;
    end else if (rd_en) begin
      sel_q <= sel;
      rsp_q <= (sel == GPIO) ? gpio_q : '0;
    end
  end

  assign o_data = (sel_q == RAM) ? ram_rdata : rsp_q;

  // GPIO register, written on the edge ending ACK.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)      gpio_q <= '0;
    else if (gpio_we) gpio_q <= i_data;
  end

  assign o_gpio = gpio_q;

`ifdef X_MEM_RSP_ERR_EN
  logic err_q;

  // Sticky error: out-of-range or misaligned access seen in ACK.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) err_q <= 1'b0;
    else if (ack && i_valid && ((sel == NONE) || (i_addr[1:0] != 2'b00))) err_q <= 1'b1;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // Loader address bits outside the word index are ignored.
  logic unused_ld_bits;
  assign unused_ld_bits = ^{i_ld_addr[31:AW+2], i_ld_addr[1:0]};

  x_mem_rsp_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (i_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_x_mem_rsp.sv
// Self-checking bench for x_mem_rsp: two instances (WAIT_CYCLES 0 and 3)
// driven from directed and randomized transactions against a word-level model.
module tb_x_mem_rsp;

  localparam int          DEPTH = 64;
  localparam logic [31:0] GPIO  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid   [2];
  logic        rnw     [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic        ld_en   [2];
  logic [31:0] ld_addr [2];
  logic [31:0] ld_data [2];
  logic        accept  [2];
  logic [31:0] rdata   [2];
  logic [31:0] gpio    [2];
  logic        err     [2];

  // Reference model state.
  logic [31:0] mem_m  [2][DEPTH];
  logic [31:0] gpio_m [2];
  logic        err_m  [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  x_mem_rsp #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .GPIO_ADDR(GPIO)) dut0 (
    .i_clk(clk), .i_nrst(nrst), .i_valid(valid[0]), .i_rnw(rnw[0]),
    .i_addr(addr[0]), .i_data(wdata[0]), .o_accept(accept[0]), .o_data(rdata[0]),
    .i_ld_en(ld_en[0]), .i_ld_addr(ld_addr[0]), .i_ld_data(ld_data[0]),
    .o_gpio(gpio[0]), .o_err(err[0])
  );

  x_mem_rsp #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .GPIO_ADDR(GPIO)) dut3 (
    .i_clk(clk), .i_nrst(nrst), .i_valid(valid[1]), .i_rnw(rnw[1]),
    .i_addr(addr[1]), .i_data(wdata[1]), .o_accept(accept[1]), .o_data(rdata[1]),
    .i_ld_en(ld_en[1]), .i_ld_addr(ld_addr[1]), .i_ld_data(ld_data[1]),
    .o_gpio(gpio[1]), .o_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // 0 = RAM, 1 = GPIO, 2 = out of range.
  function automatic int region(input logic [31:0] a);
    if ((a >> 2) == (GPIO >> 2)) return 1;
    if (a < DEPTH * 4)           return 0;
    return 2;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    case (region(a))
      0:       return mem_m[d][a / 4];
      1:       return gpio_m[d];
      default: return 32'h0;
    endcase
  endfunction

  function automatic int latency(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Loader write of one word; starts and ends at a negedge.
  task automatic load(input int d, input int idx, input logic [31:0] v);
    ld_en[d]   = 1'b1;
    ld_addr[d] = 32'(idx * 4);
    ld_data[d] = v;
    @(negedge clk);
    ld_en[d]   = 1'b0;
    mem_m[d][idx] = v;
  endtask

  // One full transaction, presented in an IDLE cycle; starts and ends at a negedge.
  task automatic req(input int d, input logic r, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [31:0] exp_rd;
    exp_rd   = model_read(d, a);
    valid[d] = 1'b1;
    rnw[d]   = r;
    addr[d]  = a;
    wdata[d] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!accept[d] && n < 20);
    check($sformatf("latency d%0d a=%h", d, a), 32'(n), 32'(latency(d)));
    if (r) check($sformatf("rdata d%0d a=%h", d, a), rdata[d], exp_rd);
    @(negedge clk);
    check($sformatf("pulse d%0d", d), 32'(accept[d]), 32'h0);
    if (!r) begin
      if (region(a) == 0)      mem_m[d][a / 4] = wd;
      else if (region(a) == 1) gpio_m[d] = wd;
    end
`ifdef X_MEM_RSP_ERR_EN
    if (region(a) == 2 || a[1:0] != 2'b00) err_m[d] = 1'b1;
`endif
    check($sformatf("gpio d%0d", d), gpio[d], gpio_m[d]);
    check($sformatf("err d%0d", d), 32'(err[d]), 32'(err_m[d]));
    if (r) check($sformatf("rdata_hold d%0d", d), rdata[d], exp_rd);
    valid[d] = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] a, v;
    int d, kind;

    nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; rnw[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      ld_en[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
      gpio_m[i] = '0; err_m[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_accept d%0d", i), 32'(accept[i]), 32'h0);
      check($sformatf("rst_data d%0d", i), rdata[i], 32'h0);
      check($sformatf("rst_gpio d%0d", i), gpio[i], 32'h0);
      check($sformatf("rst_err d%0d", i), 32'(err[i]), 32'h0);
    end
    nrst = 1'b1;
    @(negedge clk);

    // Fill both RAMs so every word has a known value.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) load(i, j, $urandom);

    // Loader-preloaded word read with zero and three wait states.
    load(0, 0, 32'h0000_0013);
    req(0, 1'b1, 32'h0, 32'h0);
    load(1, 1, 32'hDEAD_BEEF);
    req(1, 1'b1, 32'h4, 32'h0);

    // GPIO write/read, out-of-range write/read, misaligned read.
    for (int i = 0; i < 2; i++) begin
      req(i, 1'b0, GPIO, 32'h0000_00A5);
      req(i, 1'b1, GPIO, 32'h0);
      req(i, 1'b0, 32'(DEPTH * 4), 32'h1234_5678);
      req(i, 1'b1, 32'(DEPTH * 4), 32'h0);
      req(i, 1'b1, 32'h0, 32'h0);
      req(i, 1'b1, 32'h0000_000D, 32'h0);
    end

    // Back-to-back read, write, read-back on the zero-wait instance.
    req(0, 1'b1, 32'h8, 32'h0);
    req(0, 1'b0, 32'h8, 32'h5A5A_1234);
    req(0, 1'b1, 32'h8, 32'h0);

    // Reset during WAIT of a write: no accept, no commit, FSM back in IDLE.
    valid[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 32'h10; wdata[1] = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    check("abort_pre_rst", 32'(accept[1]), 32'h0);
    nrst = 1'b0;
    valid[1] = 1'b0;
    @(negedge clk);
    check("abort_in_rst", 32'(accept[1]), 32'h0);
    nrst = 1'b1;
    for (int i = 0; i < 2; i++) begin gpio_m[i] = '0; err_m[i] = 1'b0; end
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= accept[1]; end
    check("abort_no_accept", 32'(seen), 32'h0);
    req(1, 1'b1, 32'h10, 32'h0);

    // Valid dropped in WAIT: no accept, write discarded.
    valid[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 32'h14; wdata[1] = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    valid[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= accept[1]; end
    check("drop_no_accept", 32'(seen), 32'h0);
    req(1, 1'b1, 32'h14, 32'h0);

    // Active loader holds off a new request in IDLE.
    valid[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 32'h18;
    ld_en[0] = 1'b1; ld_addr[0] = 32'h28; ld_data[0] = 32'h7777_0028;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= accept[0]; end
    check("ld_block", 32'(seen), 32'h0);
    ld_en[0] = 1'b0;
    mem_m[0][10] = 32'h7777_0028;
    n = 0;
    do begin @(negedge clk); n++; end while (!accept[0] && n < 20);
    check("ld_release_latency", 32'(n), 32'h1);
    check("ld_release_rdata", rdata[0], mem_m[0][6]);
    @(negedge clk);
    valid[0] = 1'b0;
    req(0, 1'b1, 32'h28, 32'h0);

    // Randomized traffic over all regions.
    for (int k = 0; k < 80; k++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 8));
      if (kind <= 5)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (kind == 6) a = GPIO;
      else if (kind == 7) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095) * 4);
      else                a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      v = $urandom;
      req(d, 1'($urandom_range(0, 1)), a, v);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/x_mem_rsp.md
Name: x_mem_rsp

Overview:
- Memory-side responder for the core's request/accept bus: single-port word RAM plus one memory-mapped GPIO register.
- Receives requests (valid, rnw, addr, data) and completes each with a one-cycle accept.
- Read data is valid in the accept cycle.
- Sits between x_top_rv32i and the testbench/top; a side-band loader preloads program memory.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- WAIT_CYCLES, 0, extra wait states inserted before each accept (0..15).
- GPIO_ADDR, 32'h8000_0000, byte address of the GPIO register.

Ports:
- i_clk  input  1  clock
- i_nrst  input  1  asynchronous active-low reset
- i_valid  input  1  request valid; held with addr/rnw/data until o_accept
- i_rnw  input  1  1 = read, 0 = write
- i_addr  input  32  byte address; bits [1:0] ignored
- i_data  input  32  write data
- o_accept  output  1  request complete; one-cycle pulse
- o_data  output  32  read data; valid while o_accept=1
- i_ld_en  input  1  loader write strobe
- i_ld_addr  input  32  loader byte address
- i_ld_data  input  32  loader data
- o_gpio  output  32  GPIO register value
- o_err  output  1  sticky access-error flag (optional feature only)

Behaviour:
- One clock i_clk; asynchronous active-low reset i_nrst.
- Reset values: state IDLE, o_accept=0, o_data=0, o_gpio=0, o_err=0, wait counter 0. RAM contents are not reset.
- Reset mid-transaction aborts it: no write commits, no accept is issued.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if i_valid & ~i_ld_en, go to ACK when WAIT_CYCLES==0, else load counter with WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement counter; at 0, go to ACK.
  - ACK: o_accept=1 for exactly this cycle, then IDLE.
- Latency: accept arrives 1+WAIT_CYCLES cycles after i_valid is first seen in IDLE.
- The requester may present a new request the cycle after ACK. The IDLE cycle in between is the minimum gap.
- Reads: o_data is registered and loaded on the edge entering ACK from the decoded address. It holds its value after ACK.
- Writes: commit on the clock edge ending the ACK cycle, using i_addr/i_data.
- Decode:
  - i_addr[31:2]==GPIO_ADDR[31:2] selects GPIO.
  - i_addr < DEPTH*4 selects RAM[i_addr[log2(DEPTH)+1:2]].
  - Anything else is out of range: reads return 0, writes are dropped, accept is still given.
- Loader: while i_ld_en=1, RAM[i_ld_addr[..:2]] <= i_ld_data each cycle. IDLE does not start a new request while the loader is active; a request already in WAIT/ACK completes normally.
- Simultaneous loader and ACK write to the same word: the loader wins.
- i_valid dropping before accept is a protocol violation. The FSM returns to IDLE on the next cycle without accepting.

Optional Feature:
- Macro X_MEM_RSP_ERR_EN.
- Defined: o_err is set in ACK for an out-of-range access, or for i_addr[1:0]!=0. It is sticky until reset.
- Undefined: o_err is tied 0 and the flag logic is absent.

Decomposition:
- Package x_mem_rsp_pkg:
  - state enum rsp_sm_t {IDLE, WAIT, ACK}
  - default GPIO_ADDR constant
  - region-select enum {RAM, GPIO, NONE}
- Sub-module x_mem_rsp_ram:
  - DEPTH-word array with one write port (request or loader, loader priority) and one registered read port.
  - Instantiated once; no reset on the array.

Test Plan:
- Load RAM[0]=32'h0000_0013 via loader; read addr 0, WAIT_CYCLES=0 -> o_accept on cycle 2 after valid, o_data=32'h0000_0013.
- WAIT_CYCLES=3: read addr 4 holding 32'hDEAD_BEEF -> accept exactly 4 cycles after valid, single-cycle pulse, o_data=32'hDEAD_BEEF.
- Write 32'h0000_00A5 to 32'h8000_0000, then read it back -> o_gpio=32'hA5 after the accept edge; read returns 32'hA5.
- Write 32'h1234_5678 to addr DEPTH*4 -> accepted, RAM unchanged; read of the same address returns 0. With X_MEM_RSP_ERR_EN, o_err=1 and it stays set.
- Back-to-back read then write (core-style): accepts on cycles 2 and 4; the write lands; no lost or duplicate accept.
- Assert i_nrst low during WAIT of a write -> o_accept stays 0, target word unchanged, FSM in IDLE after release.
